// File: rtl/ksa_controller.sv
// -----------------------------------------------------------------------------
// ksa_controller
//
// Purpose
//   Drives an external 256 x 8 S-memory through the RC4 setup phase:
//     1. INIT : s[i] = i for i = 0..255 (one write per cycle, 256 cycles).
//     2. KSA  : for i = 0..255
//                 j = j + s[i] + key[i mod KEY_BYTES]
//                 swap(s[i], s[j])
//               Each i takes six cycles: read s[i], capture, read s[j],
//               capture, write s[i], write s[j].
//   A run lasts 1792 busy cycles. The controller then parks in DONE until
//   the requester drops start.
//
// Parameters
//   KEY_BYTES   number of key bytes, used cyclically (1..32).
//
// Ports
//   CLOCK_50     in   1            sole clock, rising edge
//   reset        in   1            asynchronous, active-high reset
//   start        in   1            level request for a full init + KSA run
//   secret_key   in   8*KEY_BYTES  key, byte 0 in the most significant byte;
//                                  must be held stable while busy
//   busy         out  1            high in every state except IDLE and DONE
//   done         out  1            high only in DONE
//   mem_address  out  8            S-memory address
//   mem_data     out  8            S-memory write data
//   mem_wren     out  1            S-memory write enable
//   mem_q        in   8            S-memory read data, one cycle after the
//                                  address is presented
// -----------------------------------------------------------------------------
module ksa_controller #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             mem_address,
  output logic [7:0]             mem_data,
  output logic                   mem_wren,
  input  logic [7:0]             mem_q
);

  // Key index width; a single-byte key still gets a 1-bit counter so the
  // vector never collapses to zero width.
  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_RD_I,
    S_CAP_I,
    S_RD_J,
    S_CAP_J,
    S_WR_I,
    S_WR_J,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      i_q,  i_d;
  logic [7:0]      j_q,  j_d;
  logic [KW-1:0]   k_q,  k_d;
  logic [7:0]      si_q, si_d;
  logic [7:0]      sj_q, sj_d;
  logic [7:0]      key_byte;

  // ---------------------------------------------------------------------------
  // Key byte selection. A compare-per-byte mux keeps every part-select
  // constant and never indexes past the last key byte.
  // ---------------------------------------------------------------------------
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (k_q == KW'(b)) begin
        key_byte = secret_key[8*(KEY_BYTES-1-b) +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned here gets a hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    si_d    = si_q;
    sj_d    = sj_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end

      S_INIT: begin
        // i wraps 255 -> 0 on the last write, leaving it ready for the KSA.
        i_d = i_q + 8'd1;
        if (i_q == 8'hFF) begin
          state_d = S_RD_I;
        end
      end

      S_RD_I: state_d = S_CAP_I;

      S_CAP_I: begin
        si_d    = mem_q;
        j_d     = j_q + mem_q + key_byte;
        state_d = S_RD_J;
      end

      S_RD_J: state_d = S_CAP_J;

      S_CAP_J: begin
        sj_d    = mem_q;
        state_d = S_WR_I;
      end

      S_WR_I: state_d = S_WR_J;

      S_WR_J: begin
        if (i_q == 8'hFF) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + 8'd1;
          k_d     = (k_q == KW'(KEY_BYTES-1)) ? '0 : k_q + KW'(1);
          state_d = S_RD_I;
        end
      end

      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from the current state only. With i = j the two writes
  // land on the same entry and the second one (si) restores the original
  // value, so no special case is needed.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy        = 1'b1;
    done        = 1'b0;
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end

      S_INIT: begin
        mem_address = i_q;
        mem_data    = i_q;
        mem_wren    = 1'b1;
      end

      S_RD_I: begin
        mem_address = i_q;
      end

      S_RD_J: begin
        mem_address = j_q;
      end

      S_WR_I: begin
        mem_address = i_q;
        mem_data    = sj_q;
        mem_wren    = 1'b1;
      end

      S_WR_J: begin
        mem_address = j_q;
        mem_data    = si_q;
        mem_wren    = 1'b1;
      end

      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end

      default: ;  // capture states drive nothing
    endcase
  end

endmodule

// File: tb/tb_ksa_controller.sv
// -----------------------------------------------------------------------------
// tb_ksa_controller
//
// Two controller instances (3-byte and 5-byte key) share one clock and reset.
// Each is attached to a behavioural 256 x 8 memory with a one-cycle
// synchronous read. Expected values are hand-computed constants or come from
// a plain software RC4 key-schedule model.
// -----------------------------------------------------------------------------
module tb_ksa_controller;

  logic        clk;
  logic        rst;

  logic        start3, busy3, done3, wren3;
  logic [23:0] key3;
  logic [7:0]  addr3, data3, q3;

  logic        start5, busy5, done5, wren5;
  logic [39:0] key5;
  logic [7:0]  addr5, data5, q5;

  logic [7:0]  mem3 [256];
  logic [7:0]  mem5 [256];
  logic [7:0]  exp_s [256];
  logic [7:0]  snap [256];
  logic [7:0]  w_addr [512];
  logic [7:0]  w_data [512];

  int n_cmp = 0;
  int n_err = 0;

  ksa_controller #(.KEY_BYTES(3)) dut3 (
    .CLOCK_50    (clk),
    .reset       (rst),
    .start       (start3),
    .secret_key  (key3),
    .busy        (busy3),
    .done        (done3),
    .mem_address (addr3),
    .mem_data    (data3),
    .mem_wren    (wren3),
    .mem_q       (q3)
  );

  ksa_controller #(.KEY_BYTES(5)) dut5 (
    .CLOCK_50    (clk),
    .reset       (rst),
    .start       (start5),
    .secret_key  (key5),
    .busy        (busy5),
    .done        (done5),
    .mem_address (addr5),
    .mem_data    (data5),
    .mem_wren    (wren5),
    .mem_q       (q5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wren3) mem3[addr3] <= data3;
    q3 <= mem3[addr3];
    if (wren5) mem5[addr5] <= data5;
    q5 <= mem5[addr5];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Software RC4 key schedule, key bytes held in the low 8*nb bits.
  task automatic model(input logic [255:0] key, input int nb);
    logic [7:0] j, t, kb;
    j = 8'd0;
    for (int i = 0; i < 256; i++) exp_s[i] = 8'(i);
    for (int i = 0; i < 256; i++) begin
      kb = key[8*(nb-1-(i % nb)) +: 8];
      j  = j + exp_s[i] + kb;
      t  = exp_s[i];
      exp_s[i] = exp_s[j];
      exp_s[j] = t;
    end
  endtask

  task automatic cmp_mem(input bit use5, input string tag);
    for (int a = 0; a < 256; a++) begin
      check(tag, use5 ? mem5[a] : mem3[a], exp_s[a]);
    end
  endtask

  // Full run on the 3-byte instance: INIT sequence, busy length, done timing,
  // KSA write pairs, DONE hold and return to IDLE, final memory.
  task automatic run3(input logic [23:0] key, input bit hand_010203, input bit expect_ieqj);
    int done_at, busy_cnt, nw, eq_cnt;
    done_at = 0; busy_cnt = 0; nw = 0; eq_cnt = 0;
    @(negedge clk);
    key3   = key;
    start3 = 1'b1;
    for (int e = 1; e <= 3000 && done_at == 0; e++) begin
      @(posedge clk);
      #1;
      if (e <= 256) begin
        check("init_wren", wren3, 1);
        check("init_addr", addr3, 32'(e - 1));
        check("init_data", data3, 32'(e - 1));
      end else if (wren3 && nw < 512) begin
        w_addr[nw] = addr3;
        w_data[nw] = data3;
        nw++;
      end
      if (busy3) busy_cnt++;
      if (done3) done_at = e;
      // start toggles while busy must have no effect
      if (e == 500) start3 = 1'b0;
      if (e == 600) start3 = 1'b1;
    end
    check("done_edge", done_at, 1793);
    check("busy_cycles", busy_cnt, 1792);
    check("ksa_writes", nw, 512);

    if (hand_010203 && nw >= 4) begin
      check("w0_addr", w_addr[0], 8'h00); check("w0_data", w_data[0], 8'h01);
      check("w1_addr", w_addr[1], 8'h01); check("w1_data", w_data[1], 8'h00);
      check("w2_addr", w_addr[2], 8'h01); check("w2_data", w_data[2], 8'h03);
      check("w3_addr", w_addr[3], 8'h03); check("w3_data", w_data[3], 8'h00);
    end
    for (int p = 0; p < nw / 2; p++) begin
      if (w_addr[2*p] == w_addr[2*p+1]) begin
        eq_cnt++;
        check("ieqj_data", w_data[2*p+1], w_data[2*p]);
      end
    end
    if (expect_ieqj) check("ieqj_seen", (eq_cnt > 0), 1);

    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check("done_hold", done3, 1);
      check("done_busy", busy3, 0);
      check("done_wren", wren3, 0);
    end
    @(negedge clk);
    start3 = 1'b0;
    @(posedge clk);
    #1;
    check("idle_done", done3, 0);
    check("idle_busy", busy3, 0);
    @(posedge clk);
    #1;
    check("idle_stay", busy3, 0);
    check("idle_addr", addr3, 0);

    model(256'(key), 3);
    cmp_mem(1'b0, "mem3");
  endtask

  initial begin
    int diffs;
    int done_at5;
    rst = 1'b0; start3 = 1'b0; start5 = 1'b0; key3 = '0; key5 = '0;
    #1 rst = 1'b1;
    #1;
    // Before any clock edge: reset alone must force the idle outputs.
    check("rst_busy3", busy3, 0); check("rst_done3", done3, 0);
    check("rst_wren3", wren3, 0); check("rst_addr3", addr3, 0);
    check("rst_data3", data3, 0);
    check("rst_busy5", busy5, 0); check("rst_done5", done5, 0);
    check("rst_wren5", wren5, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed key 010203: hand-checked first two passes plus model compare.
    run3(24'h010203, 1'b1, 1'b0);

    // Abort at i = 100: reset mid-KSA, no writes afterwards.
    @(negedge clk);
    key3   = 24'h010203;
    start3 = 1'b1;
    repeat (257 + 600 + 2) @(posedge clk);
    #1;
    check("pre_abort_busy", busy3, 1);
    for (int a = 0; a < 256; a++) snap[a] = mem3[a];
    #2 rst = 1'b1;
    #1;
    check("abort_wren", wren3, 0);
    check("abort_busy", busy3, 0);
    check("abort_addr", addr3, 0);
    check("abort_data", data3, 0);
    start3 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("abort_hold_wren", wren3, 0);
    end
    diffs = 0;
    for (int a = 0; a < 256; a++) if (mem3[a] !== snap[a]) diffs++;
    check("abort_no_write", diffs, 0);
    @(negedge clk);
    rst = 1'b0;

    // Restart after abort with a zero key: INIT from 0, i=j swap at i=0.
    run3(24'h000000, 1'b0, 1'b1);

    // Five-byte key exercises the key index wrap at 4 -> 0.
    @(negedge clk);
    key5   = 40'h0102030405;
    start5 = 1'b1;
    done_at5 = 0;
    for (int e = 1; e <= 3000 && done_at5 == 0; e++) begin
      @(posedge clk);
      #1;
      if (done5) done_at5 = e;
    end
    check("done_edge5", done_at5, 1793);
    @(negedge clk);
    start5 = 1'b0;
    @(posedge clk);
    #1;
    check("idle_done5", done5, 0);
    model(256'(key5), 5);
    cmp_mem(1'b1, "mem5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
